pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the MIPS datapath. It splits a WIDTH-bit operation into SEGS equal segments and computes one segment per pipeline stage, with the carry registered between stages. It accepts one operation per clock under a valid/ready handshake and reports carry, signed overflow and zero flags. It is intended for the EX stage and for address/branch-target arithmetic where the 32-bit combinational carry chain limits clock rate.

---
 rtl/pipelined_adder.sv | 113 +++++++++++
 tb/tb_pipelined_adder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Segmented add/sub: one SW-bit slice per stage, carry registered between stages; SEGS cycles latency.
// Single global advance (!out_valid || out_ready) freezes every stage on output stall; in_ready == advance.
module pipelined_adder #(
   parameter int WIDTH = 32,
   parameter int SEGS  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             zero
);
   localparam int SW = WIDTH / SEGS;

   logic [SEGS-1:0]            vld_q, vld_d, cy_q, cy_d;
   logic [SEGS-1:0][WIDTH-1:0] sum_q, sum_d, a_q, a_d, b_q, b_d;
   logic                       ovf_q, ovf_d, zero_q, zero_d;
   logic                       advance;

   // Inputs seen by each stage: stage 0 from the ports, stage k from register k-1.
   logic [SEGS-1:0]            st_vld, st_cin;
   logic [SEGS-1:0][WIDTH-1:0] st_a, st_b, st_sum;
   logic [SW:0]                seg_res;

   // Final-stage operand copies are never consumed downstream.
   logic unused_final_ops;
   assign unused_final_ops = ^{a_q[SEGS-1], b_q[SEGS-1]};

   assign advance = !vld_q[SEGS-1] || out_ready;

   always_comb begin
      st_vld    = '0;
      st_cin    = '0;
      st_a      = '0;
      st_b      = '0;
      st_sum    = '0;
      st_vld[0] = in_valid;
      st_a[0]   = in_1;
      st_b[0]   = sub ? ~in_2 : in_2;
      st_cin[0] = sub | c_in;
      for (int k = 1; k < SEGS; k++) begin
         st_vld[k] = vld_q[k-1];
         st_a[k]   = a_q[k-1];
         st_b[k]   = b_q[k-1];
         st_cin[k] = cy_q[k-1];
         st_sum[k] = sum_q[k-1];
      end
   end

   always_comb begin
      vld_d   = vld_q;
      cy_d    = cy_q;
      sum_d   = sum_q;
      a_d     = a_q;
      b_d     = b_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      seg_res = '0;
      if (advance) begin
         for (int k = 0; k < SEGS; k++) begin
            seg_res = {1'b0, st_a[k][k*SW +: SW]} + {1'b0, st_b[k][k*SW +: SW]}
                    + {{SW{1'b0}}, st_cin[k]};
            vld_d[k]              = st_vld[k];
            a_d[k]                = st_a[k];
            b_d[k]                = st_b[k];
            cy_d[k]               = seg_res[SW];
            sum_d[k]              = st_sum[k];
            sum_d[k][k*SW +: SW]  = seg_res[SW-1:0];
         end
         // a^b^s at the MSB recovers the carry into the MSB.
         ovf_d  = st_a[SEGS-1][WIDTH-1] ^ st_b[SEGS-1][WIDTH-1]
                ^ sum_d[SEGS-1][WIDTH-1] ^ cy_d[SEGS-1];
         zero_d = (sum_d[SEGS-1] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         cy_q   <= '0;
         sum_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         cy_q   <= cy_d;
         sum_q  <= sum_d;
         a_q    <= a_d;
         b_q    <= b_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign in_ready  = advance;
   assign out_valid = vld_q[SEGS-1];
   assign sum       = sum_q[SEGS-1];
   assign c_out     = cy_q[SEGS-1];
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomized checks of pipelined_adder (SEGS=2 main instance, SEGS=1/4/8 for carry chain).
module tb_pipelined_adder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, c_in, sub, out_valid, out_ready;
   logic [31:0] in_1, in_2, sum;
   logic        c_out, overflow, zero;

   logic        aux_vld, aux_rdy;
   logic [2:0]  ax_in_rdy, ax_vld, ax_c, ax_ovf, ax_zero;
   logic [31:0] ax_sum [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(32), .SEGS(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_1(in_1), .in_2(in_2), .c_in(c_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .c_out(c_out), .overflow(overflow), .zero(zero));

   pipelined_adder #(.WIDTH(32), .SEGS(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(aux_vld), .in_ready(ax_in_rdy[0]),
      .in_1(in_1), .in_2(in_2), .c_in(c_in), .sub(sub),
      .out_valid(ax_vld[0]), .out_ready(aux_rdy), .sum(ax_sum[0]),
      .c_out(ax_c[0]), .overflow(ax_ovf[0]), .zero(ax_zero[0]));

   pipelined_adder #(.WIDTH(32), .SEGS(4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(aux_vld), .in_ready(ax_in_rdy[1]),
      .in_1(in_1), .in_2(in_2), .c_in(c_in), .sub(sub),
      .out_valid(ax_vld[1]), .out_ready(aux_rdy), .sum(ax_sum[1]),
      .c_out(ax_c[1]), .overflow(ax_ovf[1]), .zero(ax_zero[1]));

   pipelined_adder #(.WIDTH(32), .SEGS(8)) u_s8 (
      .clk(clk), .rst_n(rst_n), .in_valid(aux_vld), .in_ready(ax_in_rdy[2]),
      .in_1(in_1), .in_2(in_2), .c_in(c_in), .sub(sub),
      .out_valid(ax_vld[2]), .out_ready(aux_rdy), .sum(ax_sum[2]),
      .c_out(ax_c[2]), .overflow(ax_ovf[2]), .zero(ax_zero[2]));

   // Reference result packed as {overflow, zero, c_out, sum}.
   function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic ci, input logic s);
      logic [31:0] bb;
      logic [32:0] r;
      logic        ov;
      bb = s ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {32'd0, (s ? 1'b1 : ci)};
      ov = (a[31] == bb[31]) && (r[31] != a[31]);
      return {ov, (r[31:0] == 32'd0), r[32], r[31:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; aux_vld = 1'b0; out_ready = 1'b1; aux_rdy = 1'b1;
      in_1 = '0; in_2 = '0; c_in = 1'b0; sub = 1'b0;
      repeat (3) tick();
      checks++;
      if ({out_valid, c_out, overflow, zero, in_ready} !== 5'b00001) begin
         errors++;
         $display("FAIL reset_flags got v/c/o/z/rdy=%b want 00001",
                  {out_valid, c_out, overflow, zero, in_ready});
      end
      checks++;
      if (sum !== 32'd0) begin
         errors++; $display("FAIL reset_sum got %h want 00000000", sum);
      end
      checks++;
      if (ax_vld !== 3'b000) begin
         errors++; $display("FAIL reset_aux_valid got %b want 000", ax_vld);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_add();
      tick();
      in_valid = 1'b1; in_1 = 32'h0000_FFFF; in_2 = 32'h0000_0001; c_in = 1'b0; sub = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_early_valid got %b want 0", out_valid);
      end
      tick();
      checks++;
      if ({out_valid, c_out, overflow, zero} !== 4'b1000 || sum !== 32'h0001_0000) begin
         errors++;
         $display("FAIL basic_add got v/c/o/z=%b sum=%h want 1000 sum=00010000",
                  {out_valid, c_out, overflow, zero}, sum);
      end
   endtask

   task automatic test_carry_all_segs();
      tick();
      out_ready = 1'b0; aux_rdy = 1'b0;
      in_valid = 1'b1; aux_vld = 1'b1;
      in_1 = 32'hFFFF_FFFF; in_2 = 32'h0; c_in = 1'b1; sub = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         tick();
         in_valid = 1'b0; aux_vld = 1'b0;
         if (c == 7) begin
            checks++;
            if (ax_vld[2] !== 1'b0) begin
               errors++; $display("FAIL carry_s8_early got %b want 0", ax_vld[2]);
            end
         end
         if (c == 8) begin
            checks++;
            if (ax_vld[2] !== 1'b1) begin
               errors++; $display("FAIL carry_s8_latency got %b want 1", ax_vld[2]);
            end
         end
      end
      checks++;
      if ({out_valid, c_out, overflow, zero} !== 4'b1101 || sum !== 32'd0) begin
         errors++;
         $display("FAIL carry_s2 got v/c/o/z=%b sum=%h want 1101 sum=00000000",
                  {out_valid, c_out, overflow, zero}, sum);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({ax_vld[i], ax_c[i], ax_ovf[i], ax_zero[i]} !== 4'b1101 || ax_sum[i] !== 32'd0) begin
            errors++;
            $display("FAIL carry_aux%0d got v/c/o/z=%b sum=%h want 1101 sum=00000000", i,
                     {ax_vld[i], ax_c[i], ax_ovf[i], ax_zero[i]}, ax_sum[i]);
         end
      end
      out_ready = 1'b1; aux_rdy = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_subtract();
      in_valid = 1'b1; sub = 1'b1; c_in = 1'b0;
      in_1 = 32'h8000_0000; in_2 = 32'h0000_0001;
      tick();
      in_1 = 32'd5; in_2 = 32'd7;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, c_out, overflow, zero} !== 4'b1110 || sum !== 32'h7FFF_FFFF) begin
         errors++;
         $display("FAIL sub_overflow got v/c/o/z=%b sum=%h want 1110 sum=7fffffff",
                  {out_valid, c_out, overflow, zero}, sum);
      end
      tick();
      checks++;
      if ({out_valid, c_out, overflow, zero} !== 4'b1000 || sum !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL sub_borrow got v/c/o/z=%b sum=%h want 1000 sum=fffffffe",
                  {out_valid, c_out, overflow, zero}, sum);
      end
      sub = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; sub = 1'b0; c_in = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) tick();
         in_valid = (c < 16);
         in_1 = 32'(c);
         in_2 = 32'(3 * c);
         #1;
         checks++;
         if (c >= 2 && c <= 17) begin
            if (out_valid !== 1'b1 || sum !== 32'(4 * (c - 2)) || in_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_cycle%0d got v=%b rdy=%b sum=%h want v=1 rdy=1 sum=%h",
                        c, out_valid, in_ready, sum, 32'(4 * (c - 2)));
            end
         end else if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_cycle%0d got v=%b want 0", c, out_valid);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      logic [34:0] sb[$];
      logic [34:0] exp_v, held;
      int sent = 0;
      int got = 0;
      held = '0;
      for (int c = 0; c < 30; c++) begin
         tick();
         in_valid  = (sent < 12);
         in_1      = 32'h1000_0000 + 32'(sent);
         in_2      = 32'(5 * sent);
         c_in      = sent[0];
         sub       = 1'b0;
         out_ready = !(c >= 6 && c <= 8);
         #1;
         if (c >= 2 && c <= 12) begin
            checks++;
            if (in_ready !== out_ready) begin
               errors++;
               $display("FAIL bp_in_ready cycle%0d got %b want %b", c, in_ready, out_ready);
            end
         end
         if (c == 6) held = {overflow, zero, c_out, sum};
         if (c >= 7 && c <= 9) begin
            checks++;
            if ({overflow, zero, c_out, sum} !== held || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL bp_hold cycle%0d got v=%b res=%h want v=1 res=%h",
                        c, out_valid, {overflow, zero, c_out, sum}, held);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL bp_extra got res=%h want no beat", sum);
            end else begin
               exp_v = sb.pop_front();
               if ({overflow, zero, c_out, sum} !== exp_v) begin
                  errors++;
                  $display("FAIL bp_data beat%0d got %h want %h", got,
                           {overflow, zero, c_out, sum}, exp_v);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(ref_model(in_1, in_2, c_in, sub));
            sent++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got != 12) begin
         errors++; $display("FAIL bp_count got %0d want 12", got);
      end
   endtask

   task automatic test_reset_mid_stream();
      tick();
      out_ready = 1'b0; sub = 1'b0; c_in = 1'b0;
      in_valid = 1'b1; in_1 = 32'h11; in_2 = 32'h22;
      tick();
      in_1 = 32'h33; in_2 = 32'h44;
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL rst_mid_pre got v=%b want 1", out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_async got v=%b rdy=%b sum=%h want v=0 rdy=1 sum=0",
                  out_valid, in_ready, sum);
      end
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_1 = 32'h55; in_2 = 32'h66;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_mid_ghost got v=%b sum=%h want v=0", out_valid, sum);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || sum !== 32'hBB) begin
         errors++;
         $display("FAIL rst_mid_first got v=%b sum=%h want v=1 sum=000000bb", out_valid, sum);
      end
      tick();
   endtask

   task automatic test_random();
      logic [34:0] sb[$];
      logic [34:0] exp_v;
      int sent = 0;
      int got = 0;
      int cyc = 0;
      while (got < 10000 && cyc < 60000) begin
         tick();
         cyc++;
         in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
         in_1      = $urandom;
         in_2      = $urandom;
         c_in      = 1'($urandom_range(1));
         sub       = 1'($urandom_range(1));
         out_ready = ($urandom_range(3) != 0);
         #1;
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL rand_extra got res=%h want no beat", sum);
            end else begin
               exp_v = sb.pop_front();
               if ({overflow, zero, c_out, sum} !== exp_v) begin
                  errors++;
                  $display("FAIL rand_data beat%0d got %h want %h", got,
                           {overflow, zero, c_out, sum}, exp_v);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(ref_model(in_1, in_2, c_in, sub));
            sent++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (got != 10000) begin
         errors++; $display("FAIL rand_timeout got %0d beats want 10000", got);
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_carry_all_segs();
      test_subtract();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_stream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
